uart_rx_8n1: RTL and testbench

- Serial receiver for the TinyTapeout user design. Accepts 8N1 UART frames on one dedicated input pin (ui_in[0] at top level) and presents each byte to the core logic through a valid/ready handshake.
- It is the receiving end of the host-side transmitter the cocotb bench drives. It sits directly behind the pin, before the command decoder in tt_um_javibajocero_top.
- A one-entry holding register decouples the core from line timing. Framing and overrun errors are flagged.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_8n1_if.sv | 18 +
 rtl/sync_ff.sv | 29 ++
 rtl/uart_rx_8n1.sv | 150 +++++++++++++++
 tb/tb_uart_rx_8n1.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared constants, state encodings and helpers for the UART receiver.
// Revision: 1.0
// ============================================================================
package uart_pkg;

    localparam int c_DATA_BITS = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

    // Never returns 0 so a counter always has at least one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_8n1_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_8n1_if
// Brief   : Valid/ready byte handshake between the receiver and its consumer.
// Revision: 1.0
// ============================================================================
interface uart_rx_8n1_if;
    import uart_pkg::*;

    logic [c_DATA_BITS-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface : uart_rx_8n1_if
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module  : sync_ff
// Brief   : N-stage single-bit synchronizer, resets to the idle-high level.
// Revision: 1.0
// ============================================================================
module sync_ff #(
    parameter int STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule : sync_ff
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_8n1
// Brief   : 8N1 UART receiver with one-entry holding register and sticky errors.
// Revision: 1.0
// ============================================================================
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int SYNC_STAGES  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      rx,
    uart_rx_8n1_if.master  rx_bus,
    output logic           frame_err,
    output logic           overrun_err,
    input  wire logic      clr_err,
    output logic           busy
);

    localparam int             c_CW   = cnt_width(CLKS_PER_BIT);
    localparam int             c_IW   = cnt_width(c_DATA_BITS);
    localparam logic [c_CW-1:0] c_TERM = c_CW'(CLKS_PER_BIT - 1);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2);
    localparam logic [c_IW-1:0] c_LAST = c_IW'(c_DATA_BITS - 1);

    logic [1:0]             r_state;
    logic [c_CW-1:0]        r_cnt;
    logic [c_IW-1:0]        r_idx;
    logic [c_DATA_BITS-1:0] r_shift;
    logic [c_DATA_BITS-1:0] r_data;
    logic                   r_valid;
    logic                   r_ferr;
    logic                   r_oerr;
    logic                   r_armed;

    logic w_rxs;
    logic w_tick;
    logic w_half;
    logic w_deliver;
    logic w_hs;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rxs)
    );

    assign w_tick    = (r_cnt == c_TERM);
    assign w_half    = (r_cnt == c_HALF);
    assign w_deliver = (r_state == c_ST_STOP) && w_tick;
    assign w_hs      = r_valid && rx_bus.rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_armed <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_rxs) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= c_ST_START;
                    end
                end
                c_ST_START: begin
                    if (w_half) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        r_state <= w_rxs ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_DATA: begin
                    if (w_tick) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rxs;
                        r_idx          <= r_idx + 1'b1;
                        if (r_idx == c_LAST) begin
                            r_state <= c_ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                c_ST_STOP: begin
                    if (w_tick) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                        // A low stop bit (break) must see the line high before re-arming.
                        r_armed <= w_rxs;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_oerr  <= 1'b0;
        end else begin
            if (w_deliver && (!r_valid || w_hs)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_hs) begin
                r_valid <= 1'b0;
            end

            if (w_deliver && !w_rxs) begin
                r_ferr <= 1'b1;
            end else if (clr_err) begin
                r_ferr <= 1'b0;
            end

            if (w_deliver && r_valid && !w_hs) begin
                r_oerr <= 1'b1;
            end else if (clr_err) begin
                r_oerr <= 1'b0;
            end
        end
    end

    assign rx_bus.rx_data  = r_data;
    assign rx_bus.rx_valid = r_valid;
    assign frame_err       = r_ferr;
    assign overrun_err     = r_oerr;
    assign busy            = (r_state != c_ST_IDLE);

endmodule : uart_rx_8n1
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_8n1
// Brief   : Directed self-checking bench for uart_rx_8n1 at 8 clocks per bit.
// Revision: 1.0
// ============================================================================
module tb_uart_rx_8n1;

    localparam int c_CPB = 8;

    logic clk;
    logic rst;
    logic rx;
    logic clr_err;
    logic frame_err;
    logic overrun_err;
    logic busy;

    int errors;
    int checks;
    int xfer_cnt;
    int base;
    logic [7:0] log_data [0:63];

    uart_rx_8n1_if u_if ();

    uart_rx_8n1 #(
        .CLKS_PER_BIT (c_CPB),
        .SYNC_STAGES  (2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_bus      (u_if),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .clr_err     (clr_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial xfer_cnt = 0;
    always @(negedge clk) begin
        if (u_if.rx_valid && u_if.rx_ready) begin
            log_data[xfer_cnt[5:0]] = u_if.rx_data;
            xfer_cnt = xfer_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        idle(c_CPB);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic pulse_clr();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        idle(1);
    endtask

    initial begin
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        rx            = 1'b1;
        clr_err       = 1'b0;
        u_if.rx_ready = 1'b0;
        idle(4);
        check("reset_valid", {31'd0, u_if.rx_valid}, 32'd0);
        check("reset_data",  {24'd0, u_if.rx_data},  32'd0);
        check("reset_ferr",  {31'd0, frame_err},     32'd0);
        check("reset_oerr",  {31'd0, overrun_err},   32'd0);
        check("reset_busy",  {31'd0, busy},          32'd0);
        rst = 1'b0;
        idle(20);

        // Single byte, consumer always ready.
        u_if.rx_ready = 1'b1;
        base = xfer_cnt;
        send_byte(8'hA5, 1'b1);
        idle(20);
        check("a5_xfers", xfer_cnt - base, 32'd1);
        check("a5_data",  {24'd0, log_data[base[5:0]]}, 32'h0A5);
        check("a5_ferr",  {31'd0, frame_err},   32'd0);
        check("a5_oerr",  {31'd0, overrun_err}, 32'd0);
        check("a5_busy",  {31'd0, busy},        32'd0);
        check("a5_valid", {31'd0, u_if.rx_valid}, 32'd0);

        // Back-to-back frames while the consumer stalls: second byte overruns.
        u_if.rx_ready = 1'b0;
        base = xfer_cnt;
        send_byte(8'h3C, 1'b1);
        send_byte(8'hF0, 1'b1);
        idle(20);
        check("ovr_valid", {31'd0, u_if.rx_valid}, 32'd1);
        check("ovr_data",  {24'd0, u_if.rx_data},  32'h03C);
        check("ovr_oerr",  {31'd0, overrun_err},   32'd1);
        u_if.rx_ready = 1'b1;
        idle(5);
        u_if.rx_ready = 1'b0;
        check("ovr_xfers",      xfer_cnt - base, 32'd1);
        check("ovr_xfer_data",  {24'd0, log_data[base[5:0]]}, 32'h03C);
        check("ovr_valid_drop", {31'd0, u_if.rx_valid}, 32'd0);
        pulse_clr();
        check("ovr_clr", {31'd0, overrun_err}, 32'd0);

        // Low stop bit: byte delivered with a frame error.
        send_byte(8'h55, 1'b0);
        idle(20);
        check("fe_valid", {31'd0, u_if.rx_valid}, 32'd1);
        check("fe_data",  {24'd0, u_if.rx_data},  32'h055);
        check("fe_ferr",  {31'd0, frame_err},     32'd1);
        check("fe_oerr",  {31'd0, overrun_err},   32'd0);
        pulse_clr();
        check("fe_clr", {31'd0, frame_err}, 32'd0);
        u_if.rx_ready = 1'b1;
        idle(2);

        // Three-clock glitch must not start a frame.
        base = xfer_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("gl_busy",  {31'd0, busy},        32'd0);
        check("gl_xfers", xfer_cnt - base,      32'd0);
        check("gl_ferr",  {31'd0, frame_err},   32'd0);
        check("gl_oerr",  {31'd0, overrun_err}, 32'd0);

        // Reset mid-frame with a byte held: everything returns to reset values.
        u_if.rx_ready = 1'b0;
        send_byte(8'h99, 1'b1);
        idle(20);
        check("rs_held", {31'd0, u_if.rx_valid}, 32'd1);
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0);
        rx = 1'b1;
        idle(3);
        check("rs_busy_mid", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
        check("rs_valid", {31'd0, u_if.rx_valid}, 32'd0);
        check("rs_data",  {24'd0, u_if.rx_data},  32'd0);
        check("rs_busy",  {31'd0, busy},          32'd0);
        idle(24);
        u_if.rx_ready = 1'b1;
        base = xfer_cnt;
        send_byte(8'h81, 1'b1);
        idle(20);
        check("rs_xfers", xfer_cnt - base, 32'd1);
        check("rs_81",    {24'd0, log_data[base[5:0]]}, 32'h081);

        // Break: one 0x00 with frame error, no repeats, then a normal byte.
        base = xfer_cnt;
        rx = 1'b0;
        idle(30 * c_CPB);
        check("brk_busy",  {31'd0, busy},   32'd0);
        check("brk_xfers", xfer_cnt - base, 32'd1);
        rx = 1'b1;
        idle(2 * c_CPB);
        send_byte(8'h12, 1'b1);
        idle(20);
        check("brk_total", xfer_cnt - base, 32'd2);
        check("brk_zero",  {24'd0, log_data[base[5:0]]},       32'd0);
        check("brk_12",    {24'd0, log_data[(base + 1) % 64]}, 32'h012);
        check("brk_ferr",  {31'd0, frame_err}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx_8n1
`default_nettype wire
